// File: rtl/alu_issue_ctrl.sv
// ALU issue controller: decodes ALUOp/funct, drives the ALU from registers,
// waits a settle time, then returns the captured result over valid/ready.
module alu_issue_ctrl #(
    parameter int WIDTH      = 32,
    parameter int SETTLE_CYC = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [1:0]       in_aluop,
    input  logic [5:0]       in_funct,
    input  logic [WIDTH-1:0] in_a,
    input  logic [WIDTH-1:0] in_b,
    output logic [2:0]       alu_ctrl,
    output logic [WIDTH-1:0] alu_srca,
    output logic [WIDTH-1:0] alu_srcb,
    input  logic [WIDTH-1:0] alu_result,
    input  logic             alu_zero,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_result,
    output logic             out_zero,
    output logic             out_branch,
    output logic             out_err
);

    typedef enum logic [1:0] {IDLE, ISSUE, CAPTURE, DONE} state_t;

    localparam int CW = (SETTLE_CYC > 1) ? $clog2(SETTLE_CYC) : 1;
    localparam logic [CW-1:0] CNT_INIT = CW'(SETTLE_CYC - 1);

    state_t          state;
    logic [CW-1:0]   cnt;
    logic            op_sub;
    logic [2:0]      dec_ctrl;
    logic            dec_ok;

    // ALUOp/funct to 3-bit ALU control; flags unsupported encodings
    always_comb begin
        dec_ctrl = 3'b010;
        dec_ok   = 1'b1;
        unique case (in_aluop)
            2'b00: dec_ctrl = 3'b010;
            2'b01: dec_ctrl = 3'b110;
            2'b10: begin
                unique case (in_funct)
                    6'b100000: dec_ctrl = 3'b010;
                    6'b100010: dec_ctrl = 3'b110;
                    6'b100100: dec_ctrl = 3'b000;
                    6'b100101: dec_ctrl = 3'b001;
                    6'b101010: dec_ctrl = 3'b111;
                    default:   dec_ok   = 1'b0;
                endcase
            end
            default: dec_ok = 1'b0;
        endcase
    end

    // Issue FSM; every output is a register so the ALU sees clean inputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            cnt        <= '0;
            op_sub     <= 1'b0;
            in_ready   <= 1'b1;
            out_valid  <= 1'b0;
            alu_ctrl   <= 3'b010;
            alu_srca   <= '0;
            alu_srcb   <= '0;
            out_result <= '0;
            out_zero   <= 1'b0;
            out_branch <= 1'b0;
            out_err    <= 1'b0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (in_valid && in_ready) begin
                        in_ready <= 1'b0;
                        op_sub   <= (in_aluop == 2'b01);
                        if (dec_ok) begin
                            alu_ctrl <= dec_ctrl;
                            alu_srca <= in_a;
                            alu_srcb <= in_b;
                            cnt      <= CNT_INIT;
                            state    <= ISSUE;
                        end else begin
                            // Illegal ops skip the ALU and answer at once
                            out_err    <= 1'b1;
                            out_result <= '0;
                            out_zero   <= 1'b0;
                            out_branch <= 1'b0;
                            out_valid  <= 1'b1;
                            state      <= DONE;
                        end
                    end
                end
                ISSUE: begin
                    if (cnt == '0) begin
                        state <= CAPTURE;
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end
                CAPTURE: begin
                    out_result <= alu_result;
                    out_zero   <= alu_zero;
                    out_branch <= alu_zero & op_sub;
                    out_err    <= 1'b0;
                    out_valid  <= 1'b1;
                    state      <= DONE;
                end
                DONE: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        in_ready  <= 1'b1;
                        state     <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_alu_issue_ctrl.sv
// Directed bench for alu_issue_ctrl with a small behavioural ALU attached.
// Expected values are hand-computed per vector.
module tb_alu_issue_ctrl;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [1:0]  in_aluop;
    logic [5:0]  in_funct;
    logic [31:0] in_a;
    logic [31:0] in_b;
    logic [2:0]  alu_ctrl;
    logic [31:0] alu_srca;
    logic [31:0] alu_srcb;
    logic [31:0] alu_result;
    logic        alu_zero;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_result;
    logic        out_zero;
    logic        out_branch;
    logic        out_err;

    int n_cmp = 0;
    int n_bad = 0;

    alu_issue_ctrl #(.WIDTH(32), .SETTLE_CYC(1)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_aluop   (in_aluop),
        .in_funct   (in_funct),
        .in_a       (in_a),
        .in_b       (in_b),
        .alu_ctrl   (alu_ctrl),
        .alu_srca   (alu_srca),
        .alu_srcb   (alu_srcb),
        .alu_result (alu_result),
        .alu_zero   (alu_zero),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_result (out_result),
        .out_zero   (out_zero),
        .out_branch (out_branch),
        .out_err    (out_err)
    );

    always #5 clk = ~clk;

    // Behavioural combinational ALU
    always_comb begin
        alu_result = 32'h0;
        case (alu_ctrl)
            3'b010:  alu_result = alu_srca + alu_srcb;
            3'b110:  alu_result = alu_srca - alu_srcb;
            3'b000:  alu_result = alu_srca & alu_srcb;
            3'b001:  alu_result = alu_srca | alu_srcb;
            3'b111:  alu_result = {31'h0, $signed(alu_srca) < $signed(alu_srcb)};
            default: alu_result = 32'h0;
        endcase
        alu_zero = (alu_result == 32'h0);
    end

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One request through the block; leaves the response in DONE
    // unless rel is set, in which case it is consumed.
    task automatic run_op(input string tag, input logic [1:0] op,
                          input logic [5:0] fn, input logic [31:0] a,
                          input logic [31:0] b, input logic [2:0] ectrl,
                          input logic [31:0] eres, input logic ez,
                          input logic eb, input logic ee, input bit rel);
        chk({tag, ".rdy0"}, 32'(in_ready), 32'd1);
        in_aluop = op;
        in_funct = fn;
        in_a     = a;
        in_b     = b;
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        if (!ee) begin
            chk({tag, ".ctrl"}, 32'(alu_ctrl), 32'(ectrl));
            chk({tag, ".srca"}, alu_srca, a);
            chk({tag, ".srcb"}, alu_srcb, b);
            chk({tag, ".rdy_issue"}, 32'(in_ready), 32'd0);
            chk({tag, ".ov_n1"}, 32'(out_valid), 32'd0);
            tick();
            chk({tag, ".ov_n2"}, 32'(out_valid), 32'd0);
            tick();
        end
        chk({tag, ".ov"}, 32'(out_valid), 32'd1);
        chk({tag, ".res"}, out_result, eres);
        chk({tag, ".zero"}, 32'(out_zero), 32'(ez));
        chk({tag, ".br"}, 32'(out_branch), 32'(eb));
        chk({tag, ".err"}, 32'(out_err), 32'(ee));
        if (rel) begin
            out_ready = 1'b1;
            tick();
            out_ready = 1'b0;
            chk({tag, ".ov_off"}, 32'(out_valid), 32'd0);
            chk({tag, ".rdy_back"}, 32'(in_ready), 32'd1);
        end
    endtask

    initial begin
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        in_aluop  = 2'b00;
        in_funct  = 6'h0;
        in_a      = 32'h0;
        in_b      = 32'h0;
        out_ready = 1'b0;
        #12;
        chk("rst.rdy", 32'(in_ready), 32'd1);
        chk("rst.ov", 32'(out_valid), 32'd0);
        chk("rst.ctrl", 32'(alu_ctrl), 32'b010);
        chk("rst.srca", alu_srca, 32'h0);
        chk("rst.srcb", alu_srcb, 32'h0);
        chk("rst.res", out_result, 32'h0);
        chk("rst.flags", {29'h0, out_zero, out_branch, out_err}, 32'h0);
        @(negedge clk);
        rst_n = 1'b1;
        tick();

        // T1 add
        run_op("t1", 2'b00, 6'h0, 32'd5, 32'd7, 3'b010, 32'd12,
               1'b0, 1'b0, 1'b0, 1'b1);
        // T2 sub equal -> branch taken
        run_op("t2", 2'b01, 6'h0, 32'h1234, 32'h1234, 3'b110, 32'h0,
               1'b1, 1'b1, 1'b0, 1'b1);
        // T3 R-type sweep
        run_op("t3.add", 2'b10, 6'b100000, 32'hC, 32'hA, 3'b010, 32'h16,
               1'b0, 1'b0, 1'b0, 1'b1);
        run_op("t3.sub", 2'b10, 6'b100010, 32'hC, 32'hA, 3'b110, 32'h2,
               1'b0, 1'b0, 1'b0, 1'b1);
        run_op("t3.and", 2'b10, 6'b100100, 32'hC, 32'hA, 3'b000, 32'h8,
               1'b0, 1'b0, 1'b0, 1'b1);
        run_op("t3.or", 2'b10, 6'b100101, 32'hC, 32'hA, 3'b001, 32'hE,
               1'b0, 1'b0, 1'b0, 1'b1);
        run_op("t3.slt", 2'b10, 6'b101010, 32'hC, 32'hA, 3'b111, 32'h0,
               1'b1, 1'b0, 1'b0, 1'b1);
        // T4 illegal encodings
        run_op("t4.fn", 2'b10, 6'b000000, 32'hC, 32'hA, 3'b000, 32'h0,
               1'b0, 1'b0, 1'b1, 1'b1);
        run_op("t4.op", 2'b11, 6'b100000, 32'h5, 32'h7, 3'b000, 32'h0,
               1'b0, 1'b0, 1'b1, 1'b1);

        // T5 back-pressure in DONE
        run_op("t5", 2'b00, 6'h0, 32'h100, 32'h23, 3'b010, 32'h123,
               1'b0, 1'b0, 1'b0, 1'b0);
        in_valid = 1'b1;
        for (int i = 0; i < 10; i++) begin
            tick();
            chk("t5.hold_ov", 32'(out_valid), 32'd1);
            chk("t5.hold_res", out_result, 32'h123);
            chk("t5.hold_rdy", 32'(in_ready), 32'd0);
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        chk("t5.rel_rdy", 32'(in_ready), 32'd1);
        chk("t5.rel_ov", 32'(out_valid), 32'd0);
        run_op("t5.next", 2'b01, 6'h0, 32'd9, 32'd4, 3'b110, 32'd5,
               1'b0, 1'b0, 1'b0, 1'b1);

        // T6 reset during ISSUE
        in_aluop = 2'b00;
        in_a     = 32'h77;
        in_b     = 32'h11;
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        chk("t6.issue", 32'(in_ready), 32'd0);
        rst_n = 1'b0;
        #1;
        chk("t6.rdy", 32'(in_ready), 32'd1);
        chk("t6.ov", 32'(out_valid), 32'd0);
        chk("t6.ctrl", 32'(alu_ctrl), 32'b010);
        chk("t6.srca", alu_srca, 32'h0);
        chk("t6.res", out_result, 32'h0);
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 6; i++) begin
            tick();
            chk("t6.no_ov", 32'(out_valid), 32'd0);
        end
        run_op("t6.after", 2'b00, 6'h0, 32'd1, 32'd2, 3'b010, 32'd3,
               1'b0, 1'b0, 1'b0, 1'b1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_bad);
        $finish;
    end

endmodule
